bram_rr_arbiter: RTL and testbench
==================================

Name: bram_rr_arbiter

Overview:
Round-robin arbiter that shares the single 32-bit port A of the shared BRAM between NUM_REQ bcrypt_loop cores using a per-core req/gnt handshake. It replaces fixed index-order sequencing, so any core may load or store whenever the port is free. All BRAM port-A outputs are registered. A watchdog reclaims the port from a core that holds it too long.

Parameters:
NUM_REQ, 14, number of requesting cores (2..32)
C_SLV_DWIDTH, 32, BRAM data width
C_MST_AWIDTH, 32, BRAM address width
MAX_HOLD, 4096, maximum consecutive granted cycles before a forced release (>=2)

Ports:
clk  in  1  single system clock; BRAM_Clk_A is driven from it
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-core request; held high for the whole burst
we_flat  in  NUM_REQ*C_SLV_DWIDTH/8  per-core byte write enables; core i occupies slice [i*4+:4]
addr_flat  in  NUM_REQ*C_MST_AWIDTH  per-core addresses, sliced the same way
wdata_flat  in  NUM_REQ*C_SLV_DWIDTH  per-core write data, sliced the same way
gnt  out  NUM_REQ  one-hot grant
rd_valid  out  NUM_REQ  one-hot pulse: BRAM_RdData_A holds that core's read word this cycle
busy  out  1  high in GRANT or RELEASE
timeout_err  out  1  sticky; set on a watchdog release
BRAM_Rst_A  out  1  constant 0
BRAM_Clk_A  out  1  = clk
BRAM_En_A  out  1  constant 1
BRAM_WE_A  out  C_SLV_DWIDTH/8  registered write enable
BRAM_Addr_A  out  C_MST_AWIDTH  registered address
BRAM_WrData_A  out  C_SLV_DWIDTH  registered write data

Behaviour:
- Reset (async, rst_n=0) forces:
  - state=IDLE, gnt=0, rd_valid=0, busy=0, timeout_err=0
  - BRAM_WE_A=0, BRAM_Addr_A=0, BRAM_WrData_A=0
  - pointer=NUM_REQ-1, hold counter=0, read pipeline cleared
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - If req!=0: pick the first set bit scanning pointer+1, pointer+2, ... with wrap modulo NUM_REQ. Register gnt to that one-hot value, zero the hold counter, go to GRANT.
  - Grant latency: req sampled high at edge N → gnt high after edge N.
- GRANT (current core c):
  - Each cycle with req[c]=1, the next edge registers we/addr/wdata slice c onto the BRAM_* outputs. Other cores' slices are ignored.
  - Any cycle granted with req[c]=1 and we slice==0 is a read. rd_valid[c] pulses two cycles later (one cycle for the address register, one for BRAM latency).
  - Writes produce no rd_valid.
  - req[c] sampled 0: gnt<=0, BRAM_WE_A<=0, pointer<=c, go to RELEASE. That cycle's slice is not forwarded.
  - Hold counter reaches MAX_HOLD-1 with req[c] still 1: same release, and timeout_err<=1. Core c is then last in round-robin order.
- RELEASE: one turnaround cycle; BRAM_WE_A=0, gnt=0; then go to IDLE. Minimum gap between two grants is 2 cycles.
- Outside GRANT-forwarding cycles: BRAM_WE_A=0; BRAM_Addr_A and BRAM_WrData_A hold their last value.
- Reads already issued still complete their rd_valid pulse after a release, as long as rst_n stays high.
- Simultaneous requests: strict round-robin from pointer. A core that drops and re-raises req immediately waits behind all other pending cores.
- req rising for another core during GRANT has no effect until IDLE.
- gnt is always one-hot or zero. rd_valid is always one-hot or zero.
- timeout_err clears only on reset.
- Reset mid-burst: all outputs return to their reset values immediately, asynchronously. Pending rd_valid pulses are dropped.

Test Plan:
- Single core: req[3]=1, writes to addr 0x10,0x11 (we=4'hF, data 0xA5A5_0000/1), then one read of 0x10 with we=0 → gnt=14'h0008 one cycle after req; BRAM_WE_A=F on the two following cycles; rd_valid[3] two cycles after the read cycle, with RdData=0xA5A5_0000.
- All 14 req high from reset, each holding for 3 cycles → grant order 0,1,…,13. Each grant lasts exactly 3 forwarding cycles and is separated by RELEASE+IDLE. gnt never has more than one bit set.
- Fairness: after core 5 releases, req[5] and req[2] are both high → core 2 is granted first, then core 5.
- Watchdog with MAX_HOLD=8: req[0] stuck high → gnt[0] drops after 8 granted cycles; timeout_err=1 and stays set; pending req[1] is granted next.
- Release corner: req[7] falls in the same cycle req[8] rises → no BRAM write from core 7's last slice. gnt[8] is high exactly 2 cycles after gnt[7] falls.
- Reset asserted mid-write burst → BRAM_WE_A, gnt and busy are 0 before the next clk edge. After rst_n=1 with req[9]=1, core 9 is granted (pointer reset to 13).

Source files
------------

// File: rtl/bram_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bram_rr_arbiter: round-robin sharing of BRAM port A between NUM_REQ cores  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bram_rr_arbiter #(
    parameter int NUM_REQ      = 14,
    parameter int C_SLV_DWIDTH = 32,
    parameter int C_MST_AWIDTH = 32,
    parameter int MAX_HOLD     = 4096
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_REQ-1:0]                    req,
    input  logic [NUM_REQ*(C_SLV_DWIDTH/8)-1:0]   we_flat,
    input  logic [NUM_REQ*C_MST_AWIDTH-1:0]       addr_flat,
    input  logic [NUM_REQ*C_SLV_DWIDTH-1:0]       wdata_flat,
    output logic [NUM_REQ-1:0]                    gnt,
    output logic [NUM_REQ-1:0]                    rd_valid,
    output logic                                  busy,
    output logic                                  timeout_err,
    output logic                                  BRAM_Rst_A,
    output logic                                  BRAM_Clk_A,
    output logic                                  BRAM_En_A,
    output logic [C_SLV_DWIDTH/8-1:0]             BRAM_WE_A,
    output logic [C_MST_AWIDTH-1:0]               BRAM_Addr_A,
    output logic [C_SLV_DWIDTH-1:0]               BRAM_WrData_A
);

    localparam int WE_W   = C_SLV_DWIDTH / 8;
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam logic [PTR_W-1:0]  PTR_RESET = PTR_W'(NUM_REQ - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [PTR_W:0]    NUM_WIDE  = (PTR_W + 1)'(NUM_REQ);

    logic [1:0]              r_state;
    logic [PTR_W-1:0]        r_ptr;
    logic [PTR_W-1:0]        r_cur;
    logic [HOLD_W-1:0]       r_hold;
    logic [NUM_REQ-1:0]      r_gnt;
    logic [NUM_REQ-1:0]      r_rd_pipe;
    logic [NUM_REQ-1:0]      r_rd_valid;
    logic                    r_timeout;
    logic [WE_W-1:0]         r_we;
    logic [C_MST_AWIDTH-1:0] r_addr;
    logic [C_SLV_DWIDTH-1:0] r_wdata;

    logic                    w_found;
    logic [PTR_W-1:0]        w_next;
    logic [PTR_W:0]          w_sum;
    logic                    w_release;
    logic [WE_W-1:0]         w_we;
    logic [C_MST_AWIDTH-1:0] w_addr;
    logic [C_SLV_DWIDTH-1:0] w_wdata;

    // First requester strictly after the pointer, wrapping; the pointer itself is checked last.
    always_comb begin
        w_found = 1'b0;
        w_next  = r_ptr;
        w_sum   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_sum = {1'b0, r_ptr} + (PTR_W + 1)'(off);
            if (w_sum >= NUM_WIDE) begin
                w_sum = w_sum - NUM_WIDE;
            end
            if (!w_found && req[w_sum[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_next  = w_sum[PTR_W-1:0];
            end
        end
    end

    assign w_we      = we_flat[r_cur*WE_W +: WE_W];
    assign w_addr    = addr_flat[r_cur*C_MST_AWIDTH +: C_MST_AWIDTH];
    assign w_wdata   = wdata_flat[r_cur*C_SLV_DWIDTH +: C_SLV_DWIDTH];
    assign w_release = !req[r_cur] || (r_hold == HOLD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ptr      <= PTR_RESET;
            r_cur      <= '0;
            r_hold     <= '0;
            r_gnt      <= '0;
            r_rd_pipe  <= '0;
            r_rd_valid <= '0;
            r_timeout  <= 1'b0;
            r_we       <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            r_we       <= '0;
            r_rd_pipe  <= '0;
            r_rd_valid <= r_rd_pipe;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_gnt   <= NUM_REQ'(1) << w_next;
                        r_cur   <= w_next;
                        r_hold  <= '0;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        // Pointer parks on the releasing core so it becomes last in line.
                        r_gnt   <= '0;
                        r_ptr   <= r_cur;
                        r_state <= ST_RELEASE;
                        if (req[r_cur]) begin
                            r_timeout <= 1'b1;
                        end
                    end else begin
                        r_we    <= w_we;
                        r_addr  <= w_addr;
                        r_wdata <= w_wdata;
                        r_hold  <= r_hold + HOLD_W'(1);
                        if (w_we == '0) begin
                            r_rd_pipe <= r_gnt;
                        end
                    end
                end
                ST_RELEASE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt           = r_gnt;
    assign rd_valid      = r_rd_valid;
    assign busy          = (r_state == ST_GRANT) || (r_state == ST_RELEASE);
    assign timeout_err   = r_timeout;
    assign BRAM_Rst_A    = 1'b0;
    assign BRAM_Clk_A    = clk;
    assign BRAM_En_A     = 1'b1;
    assign BRAM_WE_A     = r_we;
    assign BRAM_Addr_A   = r_addr;
    assign BRAM_WrData_A = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_bram_rr_arbiter.sv
`default_nettype none
// Self-checking bench for bram_rr_arbiter with a behavioural BRAM on port A.
module tb_bram_rr_arbiter;

    localparam int N  = 14;
    localparam int MH = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*4-1:0]  we_flat = '0;
    logic [N*32-1:0] addr_flat = '0;
    logic [N*32-1:0] wdata_flat = '0;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rd_valid;
    logic            busy;
    logic            timeout_err;
    logic            BRAM_Rst_A;
    logic            BRAM_Clk_A;
    logic            BRAM_En_A;
    logic [3:0]      BRAM_WE_A;
    logic [31:0]     BRAM_Addr_A;
    logic [31:0]     BRAM_WrData_A;

    always #5 clk = ~clk;

    bram_rr_arbiter #(
        .NUM_REQ(N), .C_SLV_DWIDTH(32), .C_MST_AWIDTH(32), .MAX_HOLD(MH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we_flat(we_flat),
        .addr_flat(addr_flat), .wdata_flat(wdata_flat), .gnt(gnt),
        .rd_valid(rd_valid), .busy(busy), .timeout_err(timeout_err),
        .BRAM_Rst_A(BRAM_Rst_A), .BRAM_Clk_A(BRAM_Clk_A), .BRAM_En_A(BRAM_En_A),
        .BRAM_WE_A(BRAM_WE_A), .BRAM_Addr_A(BRAM_Addr_A), .BRAM_WrData_A(BRAM_WrData_A)
    );

    // One-cycle-latency BRAM model with byte enables
    logic [31:0] mem [0:255];
    logic [31:0] rd_data;
    int          bad_wr = 0;
    always @(posedge BRAM_Clk_A) begin
        for (int b = 0; b < 4; b++) begin
            if (BRAM_WE_A[b]) mem[BRAM_Addr_A[7:0]][b*8 +: 8] <= BRAM_WrData_A[b*8 +: 8];
        end
        if (BRAM_WE_A != 4'h0 && BRAM_Addr_A[7:0] == 8'h21) bad_wr <= bad_wr + 1;
        rd_data <= mem[BRAM_Addr_A[7:0]];
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct { int core; logic [31:0] data; } rd_exp_t;
    typedef struct { int prev; logic [N-1:0] mask; int exp_idx; } arb_vec_t;

    rd_exp_t  rd_q[$];
    int       gnt_q[$];
    rd_exp_t  rd_e;
    int       gnt_e;
    logic [N-1:0] prev_gnt = '0;

    // Continuous monitor: one-hot properties and the two scoreboards
    always @(negedge clk) begin
        if (rst_n) begin
            check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            check("rd_valid_onehot0", 32'($onehot0(rd_valid)), 32'd1);
            if (rd_valid != '0) begin
                if (rd_q.size() == 0) begin
                    check("rd_valid_unexpected", 32'(rd_valid), 32'd0);
                end else begin
                    rd_e = rd_q.pop_front();
                    check("rd_valid_core", 32'(rd_valid), 32'd1 << rd_e.core);
                    check("rd_data", rd_data, rd_e.data);
                end
            end
            if (prev_gnt == '0 && gnt != '0 && gnt_q.size() != 0) begin
                gnt_e = gnt_q.pop_front();
                check("gnt_order", 32'(gnt), 32'd1 << gnt_e);
            end
        end
        prev_gnt <= gnt;
    end

    task automatic set_slice(input int c, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        we_flat[c*4 +: 4]     = w;
        addr_flat[c*32 +: 32] = a;
        wdata_flat[c*32 +: 32] = d;
    endtask

    task automatic wait_gnt(input int c, input string name);
        int n = 0;
        while (!gnt[c] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(gnt[c]), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = '0; we_flat = '0; addr_flat = '0; wdata_flat = '0;
        rd_q.delete();
        gnt_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    arb_vec_t vecs [8];
    int cnt [N];
    int fwd, gap, len, hi, n;
    bit seen, done;

    initial begin
        vecs[0] = '{prev: 5,  mask: 14'h0024, exp_idx: 2};
        vecs[1] = '{prev: 5,  mask: 14'h0020, exp_idx: 5};
        vecs[2] = '{prev: 13, mask: 14'h2001, exp_idx: 0};
        vecs[3] = '{prev: 0,  mask: 14'h2003, exp_idx: 1};
        vecs[4] = '{prev: 3,  mask: 14'h000C, exp_idx: 2};
        vecs[5] = '{prev: 10, mask: 14'h1200, exp_idx: 12};
        vecs[6] = '{prev: 12, mask: 14'h1800, exp_idx: 11};
        vecs[7] = '{prev: 7,  mask: 14'h3FFF, exp_idx: 8};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        check("rst_we", 32'(BRAM_WE_A), 32'd0);
        check("rst_addr", BRAM_Addr_A, 32'd0);
        check("rst_wdata", BRAM_WrData_A, 32'd0);
        check("bram_en", 32'(BRAM_En_A), 32'd1);
        check("bram_rst", 32'(BRAM_Rst_A), 32'd0);
        rst_n = 1'b1;

        // Single core: two writes and a read
        set_slice(3, 4'hF, 32'h10, 32'hA5A5_0000);
        req[3] = 1'b1;
        @(negedge clk);
        check("t1_gnt_latency", 32'(gnt), 32'h0008);
        check("t1_busy", 32'(busy), 32'd1);
        set_slice(3, 4'hF, 32'h10, 32'hA5A5_0000);
        @(negedge clk);
        check("t1_we0", 32'(BRAM_WE_A), 32'hF);
        check("t1_addr0", BRAM_Addr_A, 32'h10);
        check("t1_wdata0", BRAM_WrData_A, 32'hA5A5_0000);
        set_slice(3, 4'hF, 32'h11, 32'hA5A5_0001);
        @(negedge clk);
        check("t1_we1", 32'(BRAM_WE_A), 32'hF);
        check("t1_addr1", BRAM_Addr_A, 32'h11);
        check("t1_wdata1", BRAM_WrData_A, 32'hA5A5_0001);
        set_slice(3, 4'h0, 32'h10, 32'h0);
        rd_q.push_back('{core: 3, data: 32'hA5A5_0000});
        @(negedge clk);
        check("t1_we_read", 32'(BRAM_WE_A), 32'h0);
        check("t1_addr_read", BRAM_Addr_A, 32'h10);
        req[3] = 1'b0;
        set_slice(3, 4'hF, 32'h77, 32'hDEAD_BEEF);
        @(negedge clk);
        check("t1_rel_gnt", 32'(gnt), 32'd0);
        check("t1_rel_we", 32'(BRAM_WE_A), 32'd0);
        check("t1_rel_busy", 32'(busy), 32'd1);
        check("t1_rel_addr_hold", BRAM_Addr_A, 32'h10);
        @(negedge clk);
        check("t1_idle_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("t1_rd_delivered", 32'(rd_q.size()), 32'd0);

        // All cores request at once, 3 forwarding cycles each
        do_reset();
        for (int i = 0; i < N; i++) begin
            set_slice(i, 4'hF, 32'h40 + 32'(i), 32'(i) << 8);
            gnt_q.push_back(i);
            cnt[i] = 0;
        end
        req = '1;
        fwd = 0; gap = 0; len = 0; seen = 1'b0; done = 1'b0;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            @(negedge clk);
            if (BRAM_WE_A == 4'hF) fwd++;
            if (gnt != '0) begin
                if (seen && gap != 0) check("t2_gap", 32'(gap), 32'd2);
                gap = 0;
                seen = 1'b1;
                len++;
                for (int i = 0; i < N; i++) begin
                    if (gnt[i]) begin
                        if (cnt[i] == 3) req[i] = 1'b0;
                        else cnt[i]++;
                    end
                end
            end else begin
                if (len != 0) check("t2_grant_len", 32'(len), 32'd4);
                len = 0;
                if (seen) gap++;
                done = (req == '0);
            end
        end
        check("t2_done", 32'(done), 32'd1);
        check("t2_fwd_total", 32'(fwd), 32'd42);
        check("t2_order_drained", 32'(gnt_q.size()), 32'd0);
        check("t2_no_timeout", 32'(timeout_err), 32'd0);

        // Round-robin choice table
        for (int v = 0; v < 8; v++) begin
            req = '0;
            req[vecs[v].prev] = 1'b1;
            wait_gnt(vecs[v].prev, "arb_ptr_setup");
            req = '0;
            @(negedge clk);
            req = vecs[v].mask;
            n = 0;
            while (gnt == '0 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("arb_vec%0d", v), 32'(gnt), 32'd1 << vecs[v].exp_idx);
            req = '0;
            repeat (2) @(negedge clk);
        end

        // Watchdog: core 0 never releases
        do_reset();
        gnt_q.push_back(0);
        gnt_q.push_back(1);
        set_slice(0, 4'hF, 32'h30, 32'h0000_0001);
        set_slice(1, 4'hF, 32'h31, 32'h0000_0002);
        req = 14'h0003;
        hi = 0;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (gnt[0]) hi++;
            else if (hi > 0) break;
            n++;
        end
        check("wd_hold_cycles", 32'(hi), 32'(MH));
        check("wd_timeout_set", 32'(timeout_err), 32'd1);
        wait_gnt(1, "wd_next_gnt1");
        req[0] = 1'b0;
        @(negedge clk);
        req[1] = 1'b0;
        repeat (3) @(negedge clk);
        check("wd_timeout_sticky", 32'(timeout_err), 32'd1);
        check("wd_order_drained", 32'(gnt_q.size()), 32'd0);

        // Release corner: req[7] falls as req[8] rises
        set_slice(7, 4'hF, 32'h20, 32'h7777_0000);
        req[7] = 1'b1;
        wait_gnt(7, "corner_gnt7");
        @(negedge clk);
        req[7] = 1'b0;
        req[8] = 1'b1;
        set_slice(7, 4'hF, 32'h21, 32'hBAD0_BAD0);
        @(negedge clk);
        check("corner_rel_gnt", 32'(gnt), 32'd0);
        check("corner_rel_we", 32'(BRAM_WE_A), 32'd0);
        @(negedge clk);
        check("corner_idle_gnt", 32'(gnt), 32'd0);
        @(negedge clk);
        check("corner_gnt8", 32'(gnt), 32'h0100);
        req[8] = 1'b0;
        repeat (3) @(negedge clk);
        check("corner_no_stray_write", 32'(bad_wr), 32'd0);

        // Asynchronous reset in the middle of a write burst
        set_slice(4, 4'hF, 32'h50, 32'h4444_0000);
        req[4] = 1'b1;
        wait_gnt(4, "rst_mid_gnt4");
        @(negedge clk);
        set_slice(4, 4'hF, 32'h51, 32'h4444_0001);
        @(negedge clk);
        check("rst_mid_we_before", 32'(BRAM_WE_A), 32'hF);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_we", 32'(BRAM_WE_A), 32'd0);
        check("rst_mid_gnt", 32'(gnt), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_timeout", 32'(timeout_err), 32'd0);
        check("rst_mid_addr", BRAM_Addr_A, 32'd0);
        rd_q.delete();
        req = '0;
        req[9] = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_after_gnt9", 32'(gnt), 32'h0200);
        req = '0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
